fixed_memory: RTL and testbench
===============================

Name: fixed_memory

Overview:
- Parametrised on-chip data memory with integrated load/store unit. Successor to the single-word fixed memory.
- Generalised in data width and depth, with byte-lane writes and sign/zero-extended byte loads.
- Multi-beat double/quad loads write back to consecutive destination registers; double/quad stores are multi-beat fills.
- Sits between the load/store issue stage and register writeback, using the codebase's REQ/ACK handshake pair.

Parameters:
DATABITWIDTH, 16, word width in bits; multiple of 8, at least 16.
REGADDRBITWIDTH, 4, destination register index width.
MEMADDRBITWIDTH, 10, byte-address bits decoded; depth = 2^MEMADDRBITWIDTH / (DATABITWIDTH/8) words.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
clk_en  in  1  global advance enable; low freezes all state and outputs
LoadStore_REQ  out  1  ready to accept an op
LoadStore_ACK  in  1  op valid
MinorOpcodeIn  in  4  [2]=store, [1:0]=size (00 byte, 01 word, 10 double, 11 quad), [3]=sign-extend byte load
DestRegisterIn  in  REGADDRBITWIDTH  first destination register
DataAddrIn  in  DATABITWIDTH  byte address
DataIn  in  DATABITWIDTH  store data
Writeback_REQ  in  1  writeback consumer ready
Writeback_ACK  out  1  writeback data valid
DestRegisterOut  out  REGADDRBITWIDTH  register for current beat
DataOut  out  DATABITWIDTH  load beat data
AccessFault  out  1  one-cycle pulse on faulting accept
Busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; Writeback_ACK, DataOut, DestRegisterOut, AccessFault, Busy all 0. LoadStore_REQ is 0 while rst is high. Memory contents are not reset. Reset mid-burst abandons the remaining beats; words already written persist.
- Accept: occurs on an edge with LoadStore_REQ & LoadStore_ACK & clk_en. LoadStore_REQ = (state==IDLE) & ~rst (& ~FlashEn when the flash feature is built).
- Addressing: little-endian; lane 0 = bits[7:0]. Word index = DataAddrIn[MEMADDRBITWIDTH-1:log2(DATABITWIDTH/8)].
- Fault conditions, any of:
  - DataAddrIn bits above MEMADDRBITWIDTH are nonzero;
  - word/double/quad access has nonzero byte offset;
  - double/quad word index is not a multiple of 2/4.
- On fault: AccessFault pulses in the cycle after accept; stores write nothing; loads still produce every beat with DataOut = 0.
- States: IDLE, WB, FILL.
- Load (IDLE->WB):
  - The accept edge reads the RAM. Writeback_ACK=1 from the next cycle, with DataOut and DestRegisterOut=DestRegisterIn.
  - Beats: 1 for byte/word, 2 for double, 4 for quad.
  - Byte load: selected lane, zero- or sign-extended per [3]. Word/double/quad: full word, [3] ignored.
  - Output holds stable until Writeback_REQ & clk_en.
  - A handshake edge with beats remaining reads the next word. State stays WB, Writeback_ACK stays 1, DestRegisterOut increments modulo 2^REGADDRBITWIDTH. Sustained rate is 1 beat/cycle.
  - Last-beat handshake returns to IDLE with Writeback_ACK=0.
- Store byte/word:
  - Written on the accept edge; byte store writes only the selected lane.
  - No writeback; state stays IDLE, so back-to-back stores run one per cycle.
- Store double/quad:
  - Accept edge writes the first word with DataIn, captured as the fill value.
  - FILL writes the remaining 1/3 consecutive words, one per clk_en cycle, then returns to IDLE. LoadStore_REQ=0 during FILL.
- Hazards:
  - A load accepted the cycle after a store returns the stored data.
  - Ops are strictly serialised, so there is no same-edge read/write conflict.
- clk_en low: no accept, no RAM write, no state/counter change; outputs hold.

Optional Feature:
FIXEDMEM_FLASH_EN
- Defined: adds ports FlashEn (in, 1), FlashAddr (in, MEMADDRBITWIDTH), FlashData (in, DATABITWIDTH).
  - When FlashEn & clk_en & state==IDLE, FlashData is written to word FlashAddr[MEMADDRBITWIDTH-1:log2(DATABITWIDTH/8)].
  - LoadStore_REQ is forced 0 while FlashEn is high.
  - FlashEn while Busy is ignored; the in-flight op completes unaffected.
- Undefined: the ports do not exist; the memory is loaded only by stores.

Test Plan:
- Store word 0xBEEF @0x0010, then load word @0x0010 to r3 -> one beat, DataOut=0xBEEF, DestRegisterOut=3, Writeback_ACK the cycle after accept.
- Store byte 0x80 @0x0011 over 0x1234, then byte load @0x0011 with [3]=1 -> 0xFF80; with [3]=0 -> 0x0080; word @0x0010 reads 0x8034.
- Quad load @0x0020 to r14, words 1,2,3,4, Writeback_REQ held 1 -> 4 consecutive beats, DataOut 1,2,3,4, regs 14,15,0,1, then IDLE.
- Double load with Writeback_REQ low for 3 cycles -> beat 0 held stable; resumes on REQ; no beat lost or duplicated.
- Quad store 0xA5A5 @0x0040 -> LoadStore_REQ low 3 cycles; words 0x20..0x23 = 0xA5A5. Word load @0x0041 -> AccessFault pulse, DataOut=0.
- Assert rst during the beat-2 wait of a quad load -> all outputs 0 immediately, LoadStore_REQ=1 after rst falls. With FIXEDMEM_FLASH_EN: flash 0x5A5A @0x0002, then load returns 0x5A5A.

Source files
------------

// File: rtl/fixed_memory.sv
// Byte-addressed data memory with load/store unit: byte-lane writes, sign/zero byte loads, multi-beat double/quad.
// Optional flash-load port when FIXEDMEM_FLASH_EN is defined.
module fixed_memory #(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4,
  parameter int MEMADDRBITWIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  output logic                       LoadStore_REQ,
  input  logic                       LoadStore_ACK,
  input  logic [3:0]                 MinorOpcodeIn,
  input  logic [REGADDRBITWIDTH-1:0] DestRegisterIn,
  input  logic [DATABITWIDTH-1:0]    DataAddrIn,
  input  logic [DATABITWIDTH-1:0]    DataIn,
  input  logic                       Writeback_REQ,
  output logic                       Writeback_ACK,
  output logic [REGADDRBITWIDTH-1:0] DestRegisterOut,
  output logic [DATABITWIDTH-1:0]    DataOut,
  output logic                       AccessFault,
  output logic                       Busy
`ifdef FIXEDMEM_FLASH_EN
  ,
  input  logic                       FlashEn,
  input  logic [MEMADDRBITWIDTH-1:0] FlashAddr,
  input  logic [DATABITWIDTH-1:0]    FlashData
`endif
);
  localparam int NBYTES = DATABITWIDTH / 8;
  localparam int OFFB   = $clog2(NBYTES);
  localparam int WIDXW  = MEMADDRBITWIDTH - OFFB;
  localparam int DEPTH  = 1 << WIDXW;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t state_q, state_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic [WIDXW-1:0]           idx_q, idx_d;
  logic [REGADDRBITWIDTH-1:0] dest_q, dest_d;
  logic [DATABITWIDTH-1:0]    data_q, data_d;
  logic [DATABITWIDTH-1:0]    fillv_q, fillv_d;
  logic                       fault_q, fault_d;
  logic                       lfault_q, lfault_d;

  logic [DATABITWIDTH-1:0] mem [DEPTH];

  logic                    accept, hs, is_store, sext, fault, flash_hold;
  logic [1:0]              size;
  logic [OFFB-1:0]         lane;
  logic [WIDXW-1:0]        acc_idx, rd_idx;
  logic [DATABITWIDTH-1:0] rd_word, ext_byte;
  logic [7:0]              byte_sel;
  logic                    mem_we;
  logic [NBYTES-1:0]       mem_wbe;
  logic [WIDXW-1:0]        mem_widx;
  logic [DATABITWIDTH-1:0] mem_wdat;

`ifdef FIXEDMEM_FLASH_EN
  assign flash_hold = FlashEn;
`else
  assign flash_hold = 1'b0;
`endif

  assign is_store = MinorOpcodeIn[2];
  assign size     = MinorOpcodeIn[1:0];
  assign sext     = MinorOpcodeIn[3];
  assign lane     = DataAddrIn[OFFB-1:0];
  assign acc_idx  = DataAddrIn[MEMADDRBITWIDTH-1:OFFB];
  assign accept   = LoadStore_REQ & LoadStore_ACK & clk_en;
  assign hs       = (state_q == WB) & Writeback_REQ & clk_en;

  assign fault = (|(DataAddrIn >> MEMADDRBITWIDTH))
               | ((size != 2'd0) & (lane != '0))
               | ((size == 2'd2) & acc_idx[0])
               | ((size == 2'd3) & (acc_idx[1:0] != 2'd0));

  // Reads use the accept address in IDLE, otherwise the next burst word.
  assign rd_idx   = (state_q == IDLE) ? acc_idx : idx_q;
  assign rd_word  = mem[rd_idx];
  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign ext_byte = sext ? {{(DATABITWIDTH-8){byte_sel[7]}}, byte_sel}
                         : {{(DATABITWIDTH-8){1'b0}}, byte_sel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else if (clk_en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_store ? (size[1] ? FILL : IDLE) : WB;
      WB:   if (hs && cnt_q == 2'd0) state_d = IDLE;
      FILL: if (cnt_q == 2'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    LoadStore_REQ = (state_q == IDLE) & ~rst & ~flash_hold;
    Writeback_ACK = (state_q == WB);
    Busy          = (state_q != IDLE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dest_d   = dest_q;
    data_d   = data_q;
    fillv_d  = fillv_q;
    lfault_d = lfault_q;
    fault_d  = 1'b0;
    mem_we   = 1'b0;
    mem_wbe  = '0;
    mem_widx = idx_q;
    mem_wdat = fillv_q;
    if (accept) begin
      fault_d  = fault;
      lfault_d = fault;
      dest_d   = DestRegisterIn;
      idx_d    = acc_idx + 1'b1;
      cnt_d    = (size == 2'd2) ? 2'd1 : (size == 2'd3) ? 2'd3 : 2'd0;
      if (is_store) begin
        fillv_d  = DataIn;
        mem_we   = ~fault;
        mem_widx = acc_idx;
        if (size == 2'd0) begin
          mem_wdat      = {NBYTES{DataIn[7:0]}};
          mem_wbe[lane] = 1'b1;
        end else begin
          mem_wdat = DataIn;
          mem_wbe  = '1;
        end
      end else begin
        data_d = fault ? '0 : ((size == 2'd0) ? ext_byte : rd_word);
      end
    end else if (hs && cnt_q != 2'd0) begin
      data_d = lfault_q ? '0 : rd_word;
      dest_d = dest_q + 1'b1;
      idx_d  = idx_q + 1'b1;
      cnt_d  = cnt_q - 2'd1;
    end else if (state_q == FILL) begin
      mem_we  = ~lfault_q;
      mem_wbe = '1;
      idx_d   = idx_q + 1'b1;
      cnt_d   = cnt_q - 2'd1;
    end
`ifdef FIXEDMEM_FLASH_EN
    else if (FlashEn && state_q == IDLE) begin
      mem_we   = 1'b1;
      mem_wbe  = '1;
      mem_widx = FlashAddr[MEMADDRBITWIDTH-1:OFFB];
      mem_wdat = FlashData;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      dest_q   <= '0;
      data_q   <= '0;
      fillv_q  <= '0;
      fault_q  <= 1'b0;
      lfault_q <= 1'b0;
    end else if (clk_en) begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
      fillv_q  <= fillv_d;
      fault_q  <= fault_d;
      lfault_q <= lfault_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (clk_en && mem_we && mem_wbe[b]) mem[mem_widx][b*8 +: 8] <= mem_wdat[b*8 +: 8];
    end
  end

  assign DataOut         = data_q;
  assign DestRegisterOut = dest_q;
  assign AccessFault     = fault_q;
endmodule

// File: tb/tb_fixed_memory.sv
// Scoreboard bench for fixed_memory: byte-array reference model, directed cases then randomized ops.
module tb_fixed_memory;
  localparam int DW = 16, RW = 4, MW = 10;

  logic clk = 1'b0;
  logic rst, clk_en, LoadStore_REQ, LoadStore_ACK;
  logic [3:0] MinorOpcodeIn;
  logic [RW-1:0] DestRegisterIn, DestRegisterOut;
  logic [DW-1:0] DataAddrIn, DataIn, DataOut;
  logic Writeback_REQ, Writeback_ACK, AccessFault, Busy;
`ifdef FIXEDMEM_FLASH_EN
  logic FlashEn = 1'b0;
  logic [MW-1:0] FlashAddr = '0;
  logic [DW-1:0] FlashData = '0;
`endif

  fixed_memory #(.DATABITWIDTH(DW), .REGADDRBITWIDTH(RW), .MEMADDRBITWIDTH(MW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .LoadStore_REQ(LoadStore_REQ), .LoadStore_ACK(LoadStore_ACK),
    .MinorOpcodeIn(MinorOpcodeIn), .DestRegisterIn(DestRegisterIn),
    .DataAddrIn(DataAddrIn), .DataIn(DataIn),
    .Writeback_REQ(Writeback_REQ), .Writeback_ACK(Writeback_ACK),
    .DestRegisterOut(DestRegisterOut), .DataOut(DataOut),
    .AccessFault(AccessFault), .Busy(Busy)
`ifdef FIXEDMEM_FLASH_EN
    , .FlashEn(FlashEn), .FlashAddr(FlashAddr), .FlashData(FlashData)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] d; logic [RW-1:0] r; } beat_t;
  beat_t sb[$];
  bit    fq[$];
  logic [7:0] mm [1024];
  int checks = 0, errors = 0;
  bit rand_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Reference: memory as bytes, little-endian words, beats pushed per load.
  task automatic model_op(input logic [3:0] op, input logic [RW-1:0] dest,
                          input logic [DW-1:0] a, input logic [DW-1:0] d);
    int n, sz, ai;
    bit f;
    beat_t b;
    sz = int'(op[1:0]);
    ai = int'(a);
    n  = (sz == 2) ? 2 : (sz == 3) ? 4 : 1;
    f  = (ai >= 1024) || (sz != 0 && ai % 2 != 0) || (sz == 2 && (ai / 2) % 2 != 0)
      || (sz == 3 && (ai / 2) % 4 != 0);
    fq.push_back(f);
    if (op[2]) begin
      if (!f) begin
        if (sz == 0) mm[ai] = d[7:0];
        else for (int k = 0; k < n; k++) begin
          mm[ai + 2*k]     = d[7:0];
          mm[ai + 2*k + 1] = d[15:8];
        end
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        if (f) b.d = '0;
        else if (sz == 0) b.d = op[3] ? {{8{mm[ai][7]}}, mm[ai]} : {8'h00, mm[ai]};
        else b.d = {mm[ai + 2*k + 1], mm[ai + 2*k]};
        b.r = RW'(int'(dest) + k);
        sb.push_back(b);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic do_op(input logic [3:0] op, input logic [RW-1:0] dest,
                       input logic [DW-1:0] a, input logic [DW-1:0] d);
    MinorOpcodeIn = op; DestRegisterIn = dest; DataAddrIn = a; DataIn = d;
    LoadStore_ACK = 1'b1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (LoadStore_REQ && clk_en) break;
      if (i > 2000) begin
        fail("accept_timeout");
        @(posedge clk); #1;
        LoadStore_ACK = 1'b0;
        return;
      end
    end
    model_op(op, dest, a, d);
    @(posedge clk); #1;
    LoadStore_ACK = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    chk(nm, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    bit pend = 0;
    bit e;
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) pend = 0;
      else begin
        if (pend) begin
          if (fq.size() == 0) fail("fault_queue_empty");
          else begin
            e = fq.pop_front();
            chk("access_fault", AccessFault, e);
          end
        end
        if (Writeback_ACK && Writeback_REQ && clk_en) begin
          if (sb.size() == 0) fail("unexpected_beat");
          else begin
            b = sb.pop_front();
            chk("beat_data", DataOut, b.d);
            chk("beat_reg", DestRegisterOut, b.r);
          end
        end
        pend = LoadStore_REQ && LoadStore_ACK && clk_en;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      clk_en        = ($urandom_range(0, 3) != 0);
      Writeback_REQ = $urandom_range(0, 1) != 0;
    end
  end

  initial begin : stim
    logic [3:0]    op;
    logic [DW-1:0] a;
    int            sz;
    rst = 1'b1; clk_en = 1'b1; LoadStore_ACK = 1'b0; MinorOpcodeIn = '0;
    DestRegisterIn = '0; DataAddrIn = '0; DataIn = '0; Writeback_REQ = 1'b1;
    @(negedge clk);
    chk("rst_req", LoadStore_REQ, 0);
    chk("rst_ack", Writeback_ACK, 0);
    chk("rst_data", DataOut, 0);
    chk("rst_reg", DestRegisterOut, 0);
    chk("rst_fault", AccessFault, 0);
    chk("rst_busy", Busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("req_after_rst", LoadStore_REQ, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 512; i++) do_op(4'b0101, '0, DW'(2*i), DW'($urandom));

    do_op(4'b0101, 4'd0, 16'h0010, 16'hBEEF);
    do_op(4'b0001, 4'd3, 16'h0010, 16'h0);
    @(negedge clk);
    chk("wb_latency", Writeback_ACK, 1);
    chk("wb_reg3", DestRegisterOut, 3);
    @(posedge clk); #1;

    do_op(4'b0101, 4'd0, 16'h0010, 16'h1234);
    do_op(4'b0100, 4'd0, 16'h0011, 16'h0080);
    do_op(4'b1000, 4'd1, 16'h0011, 16'h0);
    do_op(4'b0000, 4'd2, 16'h0011, 16'h0);
    do_op(4'b0001, 4'd4, 16'h0010, 16'h0);
    drain("byte_drain");

    for (int i = 0; i < 4; i++) do_op(4'b0101, '0, DW'(16'h0020 + 2*i), DW'(i + 1));
    do_op(4'b0011, 4'd14, 16'h0020, 16'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("quad_stream_ack", Writeback_ACK, 1);
    end
    @(negedge clk);
    chk("quad_idle_ack", Writeback_ACK, 0);
    chk("quad_idle_busy", Busy, 0);
    @(posedge clk); #1;

    Writeback_REQ = 1'b0;
    do_op(4'b0010, 4'd6, 16'h0024, 16'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dbl_hold_ack", Writeback_ACK, 1);
      chk("dbl_hold_data", DataOut, sb[0].d);
      chk("dbl_hold_pending", sb.size(), 2);
    end
    @(posedge clk); #1 Writeback_REQ = 1'b1;
    drain("dbl_drain");

    do_op(4'b0111, 4'd0, 16'h0040, 16'hA5A5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fill_req_low", LoadStore_REQ, 0);
    end
    @(negedge clk);
    chk("fill_req_back", LoadStore_REQ, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) do_op(4'b0001, DW'(i), DW'(16'h0040 + 2*i), 16'h0);
    do_op(4'b0001, 4'd9, 16'h0041, 16'h0);
    drain("fill_drain");

    do_op(4'b0011, 4'd0, 16'h0020, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 Writeback_REQ = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_ack", Writeback_ACK, 0);
    chk("midrst_data", DataOut, 0);
    chk("midrst_reg", DestRegisterOut, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_req", LoadStore_REQ, 0);
    sb.delete();
    fq.delete();
    @(posedge clk); #1 rst = 1'b0; Writeback_REQ = 1'b1;
    @(negedge clk);
    chk("midrst_req_back", LoadStore_REQ, 1);
    @(posedge clk); #1;

`ifdef FIXEDMEM_FLASH_EN
    FlashEn = 1'b1; FlashAddr = 10'h002; FlashData = 16'h5A5A;
    @(negedge clk);
    chk("flash_req_low", LoadStore_REQ, 0);
    @(posedge clk); #1 FlashEn = 1'b0;
    mm[2] = 8'h5A; mm[3] = 8'h5A;
    do_op(4'b0001, 4'd5, 16'h0002, 16'h0);
    drain("flash_drain");
`endif

    rand_mode = 1;
    for (int i = 0; i < 400; i++) begin
      sz = $urandom_range(0, 3);
      op = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'(sz)};
      if ($urandom_range(0, 7) == 0) a = DW'($urandom);
      else a = DW'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0 && sz != 0) a = a & ~DW'((2 << sz) - 1);
      do_op(op, RW'($urandom), a, DW'($urandom));
    end
    rand_mode = 0;
    @(posedge clk); #2;
    clk_en = 1'b1; Writeback_REQ = 1'b1;
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
